// File: rtl/jtframe_scan2x_ctrl.sv
// jtframe_scan2x_ctrl: ping-pong line-buffer sequencer for a x2 scan doubler
// ports: base_cen/basex2_cen pixel enables, HS input sync (active high), scanlines dim enable;
//  wr_en/wr_addr/wr_bank drive the line RAM write side, rd_addr/rd_bank/rd_dim the read side,
//  x2_HS is the doubled sync, locked/line_len report the measured input line
module jtframe_scan2x_ctrl #(
  parameter int AW         = 9,
  parameter int LOCK_LINES = 2,
  parameter int HSW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          base_cen,
  input  logic          basex2_cen,
  input  logic          HS,
  input  logic          scanlines,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          wr_bank,
  output logic [AW-1:0] rd_addr,
  output logic          rd_bank,
  output logic          rd_dim,
  output logic          x2_HS,
  output logic          locked,
  output logic [AW:0]   line_len
);
  typedef enum logic [1:0] {WAIT, MEAS, LOCK} state_t;
  localparam logic [AW-1:0] MAX      = '1;
  localparam logic [AW-1:0] HSW_LAST = AW'(HSW - 1);
  state_t state_q, state_d;
  logic hs_q, hs_d, hs_rise, ovf, meas, same, lock, last, start;
  logic [AW-1:0] cnt_q, cnt_d, wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d, hcnt_q, hcnt_d;
  logic [AW:0] line_len_q, line_len_d, len_new;
  logic [3:0] match_q, match_d;
  logic wr_en_q, wr_en_d, wr_bank_q, wr_bank_d, pass_q, pass_d, done_q, done_d;
  logic rd_dim_q, rd_dim_d, x2_hs_q, x2_hs_d, locked_q, locked_d;
  always_comb begin
    hs_d       = base_cen ? HS : hs_q;
    hs_rise    = base_cen & HS & ~hs_q;
    // pixel counter saturates; one more pixel past the end is an overflow
    ovf        = base_cen & ~hs_rise & (cnt_q == MAX);
    cnt_d      = !base_cen ? cnt_q : hs_rise ? '0 : ovf ? cnt_q : cnt_q + AW'(1);
    wr_en_d    = base_cen & (state_q != WAIT) & ~ovf;
    wr_addr_d  = wr_en_d ? cnt_d : wr_addr_q;
    meas       = hs_rise & (state_q != WAIT);
    wr_bank_d  = wr_bank_q ^ meas;
    len_new    = {1'b0, cnt_q} + (AW+1)'(1);
    same       = len_new == line_len_q;
    line_len_d = meas ? len_new : line_len_q;
  end
  // match_cnt counts consecutive equal lines; 0 means no line measured yet since WAIT
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    case (state_q)
      WAIT: begin
        match_d = '0;
        state_d = hs_rise ? MEAS : WAIT;
      end
      MEAS: begin
        if (ovf) state_d = WAIT;
        else if (hs_rise) begin
          match_d = (same && match_q != '0) ? match_q + 4'd1 : 4'd1;
          state_d = (match_d == 4'(LOCK_LINES)) ? LOCK : MEAS;
        end
      end
      LOCK: begin
        if (ovf) state_d = WAIT;
        else if (hs_rise && !same) begin
          match_d = 4'd1;
          state_d = MEAS;
        end
      end
      default: state_d = WAIT;
    endcase
  end
  always_comb begin
    locked_d  = state_q == LOCK;
    lock      = state_q == LOCK;
    last      = {1'b0, rd_addr_q} == line_len_q - (AW+1)'(1);
    // a pass begins on the input line start or when pass 0 wraps into pass 1
    start     = basex2_cen & lock & (hs_rise | (last & ~pass_q & ~done_q));
    rd_addr_d = !lock ? '0 : !basex2_cen ? rd_addr_q : hs_rise ? '0 : done_q ? rd_addr_q :
                last ? (pass_q ? rd_addr_q : '0) : rd_addr_q + AW'(1);
    pass_d    = !lock ? 1'b0 : !basex2_cen ? pass_q : hs_rise ? 1'b0 : (last & ~done_q) | pass_q;
    done_d    = !lock ? 1'b0 : !basex2_cen ? done_q : hs_rise ? 1'b0 : done_q | (last & pass_q);
    rd_dim_d  = !lock ? 1'b0 : basex2_cen ? scanlines & pass_d : rd_dim_q;
    x2_hs_d   = !lock ? HS : !basex2_cen ? x2_hs_q : start ? 1'b1 :
                (x2_hs_q && hcnt_q == HSW_LAST) ? 1'b0 : x2_hs_q;
    hcnt_d    = !lock ? '0 : !basex2_cen ? hcnt_q : start ? '0 :
                (x2_hs_q && hcnt_q != HSW_LAST) ? hcnt_q + AW'(1) : hcnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= WAIT;
      hs_q       <= 1'b0;
      cnt_q      <= '0;
      match_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_bank_q  <= 1'b0;
      line_len_q <= '0;
      rd_addr_q  <= '0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_dim_q   <= 1'b0;
      x2_hs_q    <= 1'b0;
      hcnt_q     <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hs_q       <= hs_d;
      cnt_q      <= cnt_d;
      match_q    <= match_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_bank_q  <= wr_bank_d;
      line_len_q <= line_len_d;
      rd_addr_q  <= rd_addr_d;
      pass_q     <= pass_d;
      done_q     <= done_d;
      rd_dim_q   <= rd_dim_d;
      x2_hs_q    <= x2_hs_d;
      hcnt_q     <= hcnt_d;
      locked_q   <= locked_d;
    end
  end
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_bank  = wr_bank_q;
  assign rd_addr  = rd_addr_q;
  assign rd_bank  = ~wr_bank_q;
  assign rd_dim   = rd_dim_q;
  assign x2_HS    = x2_hs_q;
  assign locked   = locked_q;
  assign line_len = line_len_q;
endmodule
